ddr_multiport_frontend: RTL and testbench

//  N-client front end for ddr_controller: arbitrates client read/write requests onto the single

---
 rtl/ddr_multiport_frontend_if.sv | 49 ++++
 rtl/ddr_multiport_frontend.sv | 193 +++++++++++++++++++
 tb/tb_ddr_multiport_frontend.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_multiport_frontend_if.sv
// Client/controller bundle for ddr_multiport_frontend.
//   slave  : view taken by the front end (client requests and controller status in,
//            grants, read returns, controller command and error flags out)
//   master : view taken by the surrounding logic (clients plus ddr_controller)
// Per-port vectors pack port i at [i*W +: W].
interface ddr_multiport_frontend_if #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DM_W      = 4
);
  // client side
  logic [NUM_PORTS-1:0]        p_req;
  logic [NUM_PORTS-1:0]        p_we;
  logic [NUM_PORTS*ADDR_W-1:0] p_addr;
  logic [NUM_PORTS*DATA_W-1:0] p_wdata;
  logic [NUM_PORTS*DM_W-1:0]   p_dm;
  logic [NUM_PORTS-1:0]        p_gnt;
  logic [DATA_W-1:0]           p_rdata;
  logic [NUM_PORTS-1:0]        p_rvalid;
  // controller side
  logic [2:0]                  ctl_icmd;
  logic [ADDR_W-1:0]           ctl_iaddr;
  logic [DATA_W-1:0]           ctl_data_in;
  logic [DM_W-1:0]             ctl_dmsel;
  logic                        ctl_datain_valid;
  logic                        ctl_busy;
  logic [DATA_W-1:0]           ctl_dataout;
  logic                        ctl_dataout_valid;
  // sticky error flags
  logic                        err_timeout;
  logic                        err_orphan;

  modport slave (
    input  p_req, p_we, p_addr, p_wdata, p_dm,
    input  ctl_busy, ctl_dataout, ctl_dataout_valid,
    output p_gnt, p_rdata, p_rvalid,
    output ctl_icmd, ctl_iaddr, ctl_data_in, ctl_dmsel, ctl_datain_valid,
    output err_timeout, err_orphan
  );

  modport master (
    output p_req, p_we, p_addr, p_wdata, p_dm,
    output ctl_busy, ctl_dataout, ctl_dataout_valid,
    input  p_gnt, p_rdata, p_rvalid,
    input  ctl_icmd, ctl_iaddr, ctl_data_in, ctl_dmsel, ctl_datain_valid,
    input  err_timeout, err_orphan
  );
endinterface

// File: rtl/ddr_multiport_frontend.sv
// N-client front end for ddr_controller. Arbitrates client read/write requests onto the
// single controller command port, waits for the controller to acknowledge with busy, and
// routes returned read data to the issuing client through an in-order tag FIFO.
// Ports:
//   clk  : system clock shared with ddr_controller
//   rst  : synchronous active-high reset
//   fe   : ddr_multiport_frontend_if.slave (client requests/grants/returns, controller
//          command/status, sticky err_timeout/err_orphan)
module ddr_multiport_frontend #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DM_W      = 4,
  parameter int unsigned RD_DEPTH  = 4,
  parameter int unsigned ARB_MODE  = 0,
  parameter int unsigned BUSY_TO   = 15
) (
  input logic                     clk,
  input logic                     rst,
  ddr_multiport_frontend_if.slave fe
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned SUM_W = IDX_W + 1;
  localparam int unsigned PTR_W = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TO_W  = $clog2(BUSY_TO + 1);

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_READ  = 3'd1;
  localparam logic [2:0] CMD_WRITE = 3'd2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     rr_q;
  logic [IDX_W-1:0]     win_q;
  logic                 rd_q;
  logic [TO_W-1:0]      wait_cnt_q;
  logic [IDX_W-1:0]     tag_mem [RD_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_PORTS-1:0] gnt_q;
  logic [DATA_W-1:0]    rdata_q;
  logic [NUM_PORTS-1:0] rvalid_q;
  logic [2:0]           icmd_q;
  logic [ADDR_W-1:0]    iaddr_q;
  logic [DATA_W-1:0]    data_q;
  logic [DM_W-1:0]      dm_q;
  logic                 dv_q;
  logic                 err_to_q;
  logic                 err_or_q;

  logic                 fifo_full_c;
  logic                 push_c;
  logic                 pop_c;
  logic                 orphan_c;
  logic [NUM_PORTS-1:0] elig_c;
  logic                 found_c;
  logic [IDX_W-1:0]     win_c;
  logic [SUM_W-1:0]     cand_c;
  logic [SUM_W-1:0]     rr_next_c;
  logic [ADDR_W-1:0]    sel_addr_c;
  logic [DATA_W-1:0]    sel_data_c;
  logic [DM_W-1:0]      sel_dm_c;

  // Reads need a free tag slot; writes are never held back by a full FIFO.
  assign fifo_full_c = (cnt_q == CNT_W'(RD_DEPTH));
  assign elig_c      = fe.p_req & (fe.p_we | {NUM_PORTS{~fifo_full_c}});
  assign push_c      = (state_q == S_ISSUE) && rd_q;
  assign pop_c       = fe.ctl_dataout_valid && (cnt_q != '0);
  assign orphan_c    = fe.ctl_dataout_valid && (cnt_q == '0);

  // Winner search: rotate from rr_q in round-robin mode, from port 0 in fixed mode.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    cand_c  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (ARB_MODE == 0) cand_c = {1'b0, rr_q} + SUM_W'(i);
      else               cand_c = SUM_W'(i);
      if (cand_c >= SUM_W'(NUM_PORTS)) cand_c = cand_c - SUM_W'(NUM_PORTS);
      if (!found_c && elig_c[cand_c[IDX_W-1:0]]) begin
        found_c = 1'b1;
        win_c   = cand_c[IDX_W-1:0];
      end
    end
  end

  // Pointer after a grant: winner + 1 modulo NUM_PORTS.
  always_comb begin
    rr_next_c = {1'b0, win_c} + SUM_W'(1);
    if (rr_next_c == SUM_W'(NUM_PORTS)) rr_next_c = '0;
  end

  // Command fields of the current winner.
  always_comb begin
    sel_addr_c = fe.p_addr[win_c*ADDR_W +: ADDR_W];
    sel_data_c = fe.p_wdata[win_c*DATA_W +: DATA_W];
    sel_dm_c   = fe.p_dm[win_c*DM_W +: DM_W];
  end

  // Tag storage: id of the port owning each outstanding read.
  always_ff @(posedge clk) begin
    if (push_c) tag_mem[wr_ptr_q] <= win_q;
  end

  // Issue FSM, tag FIFO bookkeeping and read-return routing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      win_q      <= '0;
      rd_q       <= 1'b0;
      wait_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      rdata_q    <= '0;
      rvalid_q   <= '0;
      icmd_q     <= CMD_NOP;
      iaddr_q    <= '0;
      data_q     <= '0;
      dm_q       <= '0;
      dv_q       <= 1'b0;
      err_to_q   <= 1'b0;
      err_or_q   <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_c && !pop_c)      cnt_q <= cnt_q + CNT_W'(1);
      else if (!push_c && pop_c) cnt_q <= cnt_q - CNT_W'(1);

      // Returns are in issue order, so the head tag names the owner.
      rvalid_q <= '0;
      if (pop_c) begin
        rdata_q  <= fe.ctl_dataout;
        rvalid_q <= NUM_PORTS'(1) << tag_mem[rd_ptr_q];
      end
      if (orphan_c) err_or_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (!fe.ctl_busy && found_c) begin
            state_q <= S_ISSUE;
            win_q   <= win_c;
            rd_q    <= ~fe.p_we[win_c];
            icmd_q  <= fe.p_we[win_c] ? CMD_WRITE : CMD_READ;
            iaddr_q <= sel_addr_c;
            data_q  <= sel_data_c;
            dm_q    <= sel_dm_c;
            dv_q    <= fe.p_we[win_c];
            gnt_q   <= NUM_PORTS'(1) << win_c;
            if (ARB_MODE == 0) rr_q <= rr_next_c[IDX_W-1:0];
          end
        end
        S_ISSUE: begin
          state_q    <= S_WAIT;
          icmd_q     <= CMD_NOP;
          dv_q       <= 1'b0;
          gnt_q      <= '0;
          wait_cnt_q <= '0;
        end
        S_WAIT: begin
          // The controller acknowledges a command by raising busy.
          if (fe.ctl_busy) begin
            state_q <= S_IDLE;
          end else if (wait_cnt_q == TO_W'(BUSY_TO - 1)) begin
            err_to_q <= 1'b1;
            state_q  <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + TO_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fe.p_gnt            = gnt_q;
  assign fe.p_rdata          = rdata_q;
  assign fe.p_rvalid         = rvalid_q;
  assign fe.ctl_icmd         = icmd_q;
  assign fe.ctl_iaddr        = iaddr_q;
  assign fe.ctl_data_in      = data_q;
  assign fe.ctl_dmsel        = dm_q;
  assign fe.ctl_datain_valid = dv_q;
  assign fe.err_timeout      = err_to_q;
  assign fe.err_orphan       = err_or_q;

endmodule

// File: tb/tb_ddr_multiport_frontend.sv
// Scoreboard bench for ddr_multiport_frontend: a round-robin instance takes the directed
// vectors, a fixed-priority instance checks starvation. Expected grants, commands and
// read returns are queued at stimulus time and popped by negedge monitors.
module tb_ddr_multiport_frontend;

  typedef struct packed {
    logic [2:0]  icmd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  dm;
    logic        dv;
  } cmd_t;

  typedef struct packed {
    logic [3:0]  oh;
    logic [31:0] data;
  } rd_t;

  logic        clk;
  logic        rst;
  bit          auto_busy;
  bit          ret_pend;
  logic [31:0] ret_val;
  int          n_vec;
  int          n_err;

  cmd_t       exp_cmd[$];
  logic [3:0] exp_gnt[$];
  rd_t        exp_rd[$];
  logic [3:0] exp_fp[$];

  ddr_multiport_frontend_if ifr ();
  ddr_multiport_frontend_if ifp ();

  ddr_multiport_frontend #(.ARB_MODE(0)) dut_rr (.clk(clk), .rst(rst), .fe(ifr));
  ddr_multiport_frontend #(.ARB_MODE(1)) dut_fp (.clk(clk), .rst(rst), .fe(ifp));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexp(input string name, input logic [127:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected output %0h, none expected", name, act);
  endtask

  // Monitor for the round-robin instance.
  always @(negedge clk) begin
    cmd_t       c;
    rd_t        r;
    logic [3:0] g;
    if (ifr.p_gnt != '0) begin
      if (exp_gnt.size() == 0) unexp("gnt", ifr.p_gnt);
      else begin g = exp_gnt.pop_front(); check("gnt", ifr.p_gnt, g); end
    end
    if (ifr.ctl_icmd != 3'd0) begin
      if (exp_cmd.size() == 0) unexp("cmd", ifr.ctl_icmd);
      else begin
        c = exp_cmd.pop_front();
        check("cmd", {ifr.ctl_icmd, ifr.ctl_iaddr, ifr.ctl_data_in, ifr.ctl_dmsel,
                      ifr.ctl_datain_valid}, c);
      end
    end
    if (ifr.p_rvalid != '0) begin
      if (exp_rd.size() == 0) unexp("rvalid", {ifr.p_rvalid, ifr.p_rdata});
      else begin r = exp_rd.pop_front(); check("rdata", {ifr.p_rvalid, ifr.p_rdata}, r); end
    end
  end

  // Monitor for the fixed-priority instance.
  always @(negedge clk) begin
    logic [3:0] g;
    if (ifp.p_gnt != '0) begin
      if (exp_fp.size() == 0) unexp("fp_gnt", ifp.p_gnt);
      else begin g = exp_fp.pop_front(); check("fp_gnt", ifp.p_gnt, g); end
    end
  end

  // Controller busy model: busy from the ISSUE cycle through the WAIT cycle.
  initial begin
    ifr.ctl_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_busy && ifr.ctl_icmd != 3'd0) begin
        ifr.ctl_busy = 1'b1;
        repeat (2) @(negedge clk);
        ifr.ctl_busy = 1'b0;
      end
    end
  end

  initial begin
    ifp.ctl_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (ifp.ctl_icmd != 3'd0) begin
        ifp.ctl_busy = 1'b1;
        repeat (2) @(negedge clk);
        ifp.ctl_busy = 1'b0;
      end
    end
  end

  // Advance n negedges: clients drop granted requests, pending return data is driven.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      ifr.p_req = ifr.p_req & ~ifr.p_gnt;
      if (ret_pend) begin
        ifr.ctl_dataout       = ret_val;
        ifr.ctl_dataout_valid = 1'b1;
        ret_pend              = 1'b0;
      end else begin
        ifr.ctl_dataout_valid = 1'b0;
      end
    end
  endtask

  // Raise a request; queue its grant and controller command in the expected order.
  task automatic issue(input int p, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    cmd_t c;
    ifr.p_we[p]           = we;
    ifr.p_addr[p*32 +: 32]  = a;
    ifr.p_wdata[p*32 +: 32] = d;
    ifr.p_dm[p*4 +: 4]      = m;
    ifr.p_req[p]          = 1'b1;
    exp_gnt.push_back(4'(1 << p));
    c = '{icmd: (we ? 3'd2 : 3'd1), addr: a, data: d, dm: m, dv: we};
    exp_cmd.push_back(c);
  endtask

  task automatic ret_exp(input int p, input logic [31:0] d);
    rd_t r;
    r = '{oh: 4'(1 << p), data: d};
    exp_rd.push_back(r);
    ret_pend = 1'b1;
    ret_val  = d;
    cyc(2);
  endtask

  task automatic ret_orphan(input logic [31:0] d);
    ret_pend = 1'b1;
    ret_val  = d;
    cyc(2);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt"},    ifr.p_gnt, 0);
    check({tag, "_rvalid"}, ifr.p_rvalid, 0);
    check({tag, "_rdata"},  ifr.p_rdata, 0);
    check({tag, "_cmd"},    {ifr.ctl_icmd, ifr.ctl_iaddr, ifr.ctl_data_in, ifr.ctl_dmsel,
                             ifr.ctl_datain_valid}, 0);
    check({tag, "_err"},    {ifr.err_timeout, ifr.err_orphan}, 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; auto_busy = 1'b1; ret_pend = 1'b0; ret_val = '0;
    ifr.p_req = '0; ifr.p_we = '0; ifr.p_addr = '0; ifr.p_wdata = '0; ifr.p_dm = '0;
    ifr.ctl_dataout = '0; ifr.ctl_dataout_valid = 1'b0;
    ifp.p_req = '0; ifp.p_we = '0; ifp.p_addr = '0; ifp.p_wdata = '0; ifp.p_dm = '0;
    ifp.ctl_dataout = '0; ifp.ctl_dataout_valid = 1'b0;
    cyc(3);
    check_zero("reset");
    rst = 1'b0;
    cyc(2);

    // Single write from port 2: command on the controller one edge after sampling.
    issue(2, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    cyc(1);
    check("t1_icmd", ifr.ctl_icmd, 3'd2);
    check("t1_dv", ifr.ctl_datain_valid, 1'b1);
    cyc(1);
    check("t1_wait_cmd", {ifr.ctl_icmd, ifr.ctl_datain_valid}, 4'h0);
    cyc(4);

    // Fresh reset, then four simultaneous reads: round-robin order 0,1,2,3.
    rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
    for (int p = 0; p < 4; p++) issue(p, 1'b0, 32'h1000 + 32'(p * 16), 32'h0, 4'hF);
    cyc(14);
    for (int p = 0; p < 4; p++) ret_exp(p, 32'hA0A0_0000 + 32'(p));
    cyc(2);
    check("t2_rdata_hold", ifr.p_rdata, 32'hA0A0_0003);

    // Fill the tag FIFO; a write still passes, the read waits for a free slot.
    for (int p = 0; p < 4; p++) issue(p, 1'b0, 32'h2000 + 32'(p * 16), 32'h0, 4'hF);
    cyc(14);
    issue(3, 1'b1, 32'h3000, 32'h3333_3333, 4'h3);
    issue(1, 1'b0, 32'h3100, 32'h0, 4'hF);
    cyc(8);
    check("t3_p1_held", ifr.p_req[1], 1'b1);
    check("t3_gnt_left", exp_gnt.size(), 1);
    ret_exp(0, 32'hB000_0000);
    ret_exp(1, 32'hB000_0001);
    ret_exp(2, 32'hB000_0002);
    ret_exp(3, 32'hB000_0003);
    ret_exp(1, 32'hB000_0004);
    cyc(4);

    // Read issue coinciding with a return, then an orphan return.
    issue(2, 1'b0, 32'h4000, 32'h0, 4'hF);
    cyc(6);
    issue(0, 1'b0, 32'h4100, 32'h0, 4'hF);
    ret_exp(2, 32'hC000_0000);
    cyc(4);
    ret_exp(0, 32'hC000_0001);
    check("t5_no_orphan", ifr.err_orphan, 1'b0);
    ret_orphan(32'hC000_0002);
    cyc(1);
    check("t5_orphan", ifr.err_orphan, 1'b1);

    // Busy never comes: timeout after BUSY_TO wait cycles, FSM still accepts work.
    auto_busy = 1'b0;
    issue(0, 1'b1, 32'h5000, 32'h0000_0055, 4'h1);
    cyc(11);
    check("t6_no_timeout_yet", ifr.err_timeout, 1'b0);
    cyc(8);
    check("t6_timeout", ifr.err_timeout, 1'b1);
    auto_busy = 1'b1;
    issue(1, 1'b1, 32'h5100, 32'h0000_5151, 4'hC);
    cyc(6);
    check("t6_sticky", ifr.err_timeout, 1'b1);

    // Reset in WAIT with two reads outstanding; the late return is an orphan.
    issue(1, 1'b0, 32'h6000, 32'h0, 4'hF);
    cyc(4);
    issue(2, 1'b0, 32'h6100, 32'h0, 4'hF);
    cyc(4);
    auto_busy = 1'b0;
    issue(3, 1'b1, 32'h6200, 32'h6262_6262, 4'h5);
    cyc(4);
    rst = 1'b1;
    cyc(1);
    check_zero("midwait_rst");
    rst = 1'b0;
    auto_busy = 1'b1;
    cyc(2);
    ret_orphan(32'hD000_0000);
    cyc(1);
    check("t6_rst_orphan", ifr.err_orphan, 1'b1);

    // Fixed priority: ports 1 and 3 both always requesting, port 1 always wins.
    ifp.p_we   = 4'b1010;
    ifp.p_addr = {32'h7300, 32'h0, 32'h7100, 32'h0};
    for (int i = 0; i < 6; i++) exp_fp.push_back(4'b0010);
    ifp.p_req = 4'b1010;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (exp_fp.size() == 0) break;
    end
    ifp.p_req = '0;
    cyc(6);

    check("left_gnt", exp_gnt.size(), 0);
    check("left_cmd", exp_cmd.size(), 0);
    check("left_rd", exp_rd.size(), 0);
    check("left_fp", exp_fp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
